bht_update_queue: RTL
=====================

Name: bht_update_queue

Overview:
- Sits directly upstream of the bht block's bht_update_i port.
- Buffers resolved-branch outcomes from the branch unit in a small in-order FIFO and drains at most one per cycle into the BHT.
- Coalesces back-to-back updates to the same PC, and absorbs BHT-side stalls, flushes and debug mode.
- Drops updates on overflow and counts every drop; the BHT is a predictor, so lost updates are tolerable.

Parameters:
- CVA6Cfg, default config_pkg::cva6_cfg_empty: core configuration; provides VLEN and BHTIndexBits.
- bht_update_t, default logic: update struct {valid, pc[VLEN], taken, metadata}, identical to the BHT's update type.
- DEPTH, default 4: number of queue entries; power of two, at least 2.
- DROP_CNT_W, default 8: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_bp_i  in  1  discard all queued updates.
- debug_mode_i  in  1  core is in debug mode.
- stall_i  in  1  BHT update port unavailable this cycle.
- resolved_i  in  bht_update_t  resolved branch; valid field qualifies it.
- bht_update_o  out  bht_update_t  update presented to the BHT.
- full_o  out  1  count equals DEPTH.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- drop_cnt_o  out  DROP_CNT_W  saturating count of dropped updates.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high, sampled on the clk_i rising edge.
- Reset values: all entries invalid, head and tail pointers 0, count_o=0, full_o=0, drop_cnt_o=0, bht_update_o.valid=0.
- Storage: circular buffer of DEPTH entries with head and tail pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. count_o is held as a separate register.
- pop = bht_update_o.valid && !stall_i.
- bht_update_o.valid = (count_o != 0) && !debug_mode_i. The other fields of bht_update_o always carry the head entry.
- Latency: an entry pushed at edge N drives bht_update_o from cycle N+1. No combinational path exists from resolved_i to bht_update_o.
- Coalescing: applies when resolved_i.valid=1, count_o is at least 1, resolved_i.pc equals the pc of the youngest entry (tail-1), and that entry is not being popped this cycle.
  - The youngest entry's taken and metadata are overwritten.
  - No allocation occurs and count_o is unchanged.
  - If count_o=1 and the head is being popped, a new entry is allocated instead.
- Push: occurs when resolved_i.valid=1, no coalesce applies, and either count_o < DEPTH or pop=1. The entry is written at tail, and tail and count advance.
- Simultaneous push and pop when full: accepted, count_o stays at DEPTH.
- Drop: occurs when resolved_i.valid=1, the queue is full, pop=0 and no coalesce applies. drop_cnt_o increments and saturates at all-ones.
- flush_bp_i=1: at the next edge head, tail and count go to 0, and any resolved_i that cycle is discarded without counting.
  - bht_update_o.valid still reflects the pre-flush head during the flush cycle; the BHT ignores updates during flush.
  - drop_cnt_o is not cleared.
- debug_mode_i=1:
  - resolved_i is discarded and not counted.
  - Output valid is forced to 0, so there is no pop.
  - Queue contents are held and drain resumes when debug mode exits.
- Priority: rst_i > flush_bp_i > debug_mode_i > normal operation.
- Reset asserted mid-drain clears the queue on the same edge; there is no partial-state recovery.

Decomposition:
- bht_update_t and bp_metadata_t stay as type parameters, built the same way as for bht, so queue and BHT always agree.
- The shared package (ariane_pkg) holds the default queue depth constant BHT_UPDATE_QUEUE_DEPTH=4.
- One natural sub-module: bhtq_ptr. It holds the head/tail/count bookkeeping (inputs push and pop, outputs pointers and full), with the data array and coalesce logic in the top.
- Expected size: about 200 RTL lines.

Test Plan:
- Reset then single update: push pc=0x1000, taken=1, index=5. Required: bht_update_o.valid=1 exactly one cycle later with identical fields, count_o 1 then 0.
- Coalesce: push pc=0x2000 taken=0 with stall_i=1, then the same pc with taken=1 on the next cycle. Required: count_o=1 and the drained entry has taken=1.
- Overflow: stall_i=1 and push 6 distinct pcs with DEPTH=4. Required: full_o=1, count_o=4, drop_cnt_o=2. On releasing the stall, the first 4 pcs drain in push order on consecutive cycles.
- Full push+pop: queue full, stall_i=0, new pc=0x3000 pushed. Required: count_o stays 4, drop_cnt_o unchanged, and 0x3000 emerges 4 cycles later.
- Flush: 3 entries queued and flush_bp_i pulsed for 1 cycle together with a valid resolved_i. Required: count_o=0 the next cycle, no further valid output, drop_cnt_o unchanged.
- Debug mode: 2 entries queued, then debug_mode_i=1 for 5 cycles with pushes offered. Required: output valid=0 and count_o=2 throughout; after exit, both original entries drain.

Source files
------------

// File: rtl/bht_update_queue_pkg.sv
// rtl/bht_update_queue_pkg.sv - shared types and constants for the BHT update queue
package bht_update_queue_pkg;

    // Core configuration slice the queue needs: PC width and BHT index width.
    typedef struct packed {
        int unsigned VLEN;
        int unsigned BHTIndexBits;
    } bhtq_cfg_t;

    localparam int unsigned DEFAULT_VLEN           = 32;
    localparam int unsigned DEFAULT_BHT_INDEX_BITS = 6;

    localparam bhtq_cfg_t BHTQ_CFG_DEFAULT = '{
        VLEN:         DEFAULT_VLEN,
        BHTIndexBits: DEFAULT_BHT_INDEX_BITS
    };

    // Default queue depth shared with the rest of the front end.
    localparam int unsigned BHT_UPDATE_QUEUE_DEPTH = 4;

    // Predictor metadata carried alongside each update (BHT index).
    typedef struct packed {
        logic [DEFAULT_BHT_INDEX_BITS-1:0] index;
    } bhtq_metadata_t;

    // Update record, laid out exactly as the BHT expects it.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_VLEN-1:0]  pc;
        logic                     taken;
        bhtq_metadata_t           metadata;
    } bhtq_update_t;

endpackage

// File: rtl/bhtq_ptr.sv
// rtl/bhtq_ptr.sv - head/tail/count bookkeeping for the BHT update queue
module bhtq_ptr #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers; DEPTH is a power of two so pointers wrap for free.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop_i) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer registers; a flush empties the queue just like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - coalescing, drop-counting FIFO in front of the BHT update port
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter bhtq_cfg_t   CVA6Cfg       = BHTQ_CFG_DEFAULT,
    parameter type         bp_metadata_t = bht_update_queue_pkg::bhtq_metadata_t,
    parameter type         bht_update_t  = bht_update_queue_pkg::bhtq_update_t,
    parameter int unsigned DEPTH         = BHT_UPDATE_QUEUE_DEPTH,
    parameter int unsigned DROP_CNT_W    = 8,
    localparam int unsigned PTR_W        = $clog2(DEPTH),
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_bp_i,
    input  logic                  debug_mode_i,
    input  logic                  stall_i,
    input  bht_update_t           resolved_i,
    output bht_update_t           bht_update_o,
    output logic                  full_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned VLEN = CVA6Cfg.VLEN;

    bht_update_t            mem_q [DEPTH];
    logic [DROP_CNT_W-1:0]  drop_cnt_q;

    logic [PTR_W-1:0] head, tail, youngest;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             out_valid;
    logic             pop;
    logic             in_valid;
    logic             coalesce;
    logic             push;
    logic             drop;
    logic [VLEN-1:0]  young_pc;
    bp_metadata_t     in_meta;

    bhtq_ptr #(
        .DEPTH (DEPTH)
    ) i_bhtq_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_bp_i),
        .push_i  (push),
        .pop_i   (pop),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count),
        .full_o  (full)
    );

    assign youngest = tail - PTR_W'(1);
    assign young_pc = mem_q[youngest].pc;
    assign in_meta  = resolved_i.metadata;

    // Debug mode hides the head from the BHT, which also freezes draining.
    assign out_valid = (count != '0) && !debug_mode_i;
    assign pop       = out_valid && !stall_i;

    // Flush and debug mode both swallow the incoming update without counting it.
    assign in_valid = resolved_i.valid && !flush_bp_i && !debug_mode_i;

    // Merge into the youngest entry unless that entry leaves the queue this cycle.
    assign coalesce = in_valid && (count != '0) && (resolved_i.pc == young_pc)
                    && !(pop && (count == CNT_W'(1)));
    assign push     = in_valid && !coalesce && (!full || pop);
    assign drop     = in_valid && !coalesce && full && !pop;

    // Entry storage: allocate at tail, or refresh outcome of the youngest on coalesce.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[tail] <= resolved_i;
        end else if (coalesce) begin
            mem_q[youngest].taken    <= resolved_i.taken;
            mem_q[youngest].metadata <= in_meta;
        end
    end

    // Saturating drop counter; survives flushes so lost updates stay visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    // Head entry drives the BHT directly from storage, qualified by out_valid.
    always_comb begin
        bht_update_o       = mem_q[head];
        bht_update_o.valid = out_valid;
    end

    assign full_o     = full;
    assign count_o    = count;
    assign drop_cnt_o = drop_cnt_q;

endmodule
